// File: rtl/osc_voice_scheduler.sv
// Phase-accumulator scheduler for several oscillator voices that share one adder.
// Each sample round advances every accumulator. It applies hard-sync and test
// resets, then streams each voice's accumulator and ring-mod information to the
// shared waveform generators.
module osc_voice_scheduler #(
    parameter int NUM_VOICES       = 3,
    parameter int ACCUMULATOR_BITS = 24,
    parameter int FREQ_BITS        = 16,
    parameter int VOICE_BITS       = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_tick,
    input  logic                        cfg_we,
    input  logic [VOICE_BITS-1:0]       cfg_voice,
    input  logic [FREQ_BITS-1:0]        cfg_freq,
    input  logic                        cfg_ringmod,
    input  logic                        cfg_sync,
    input  logic                        cfg_test,
    output logic [ACCUMULATOR_BITS-1:0] accumulator,
    output logic [VOICE_BITS-1:0]       voice_idx,
    output logic                        en_ringmod,
    output logic                        ringmod_source,
    output logic                        out_valid,
    output logic                        round_done,
    output logic                        busy,
    output logic                        overrun
);

    localparam int                    MSB    = ACCUMULATOR_BITS - 1;
    localparam logic [VOICE_BITS-1:0] LAST_V = VOICE_BITS'(NUM_VOICES - 1);
    localparam logic [VOICE_BITS-1:0] ONE_V  = VOICE_BITS'(1);

    typedef enum logic [1:0] {IDLE, UPDATE, EMIT} state_e;
    typedef logic [ACCUMULATOR_BITS-1:0] acc_t;
    typedef logic [FREQ_BITS-1:0]        freq_t;

    state_e                  state_q, state_d;
    logic [VOICE_BITS-1:0]   v_q, v_d;
    logic                    tick_accept;
    logic                    overrun_q, overrun_d;

    // Live configuration, written at any time.
    freq_t                   freq_q [NUM_VOICES];
    freq_t                   freq_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   ringmod_q, ringmod_d, sync_q, sync_d, test_q, test_d;

    // Shadow configuration, frozen for the duration of a round.
    freq_t                   sh_freq_q [NUM_VOICES];
    freq_t                   sh_freq_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   sh_ringmod_q, sh_ringmod_d, sh_sync_q, sh_sync_d, sh_test_q, sh_test_d;

    // Accumulators and the MSB history used for hard-sync edge detection.
    acc_t                    acc_q [NUM_VOICES];
    acc_t                    acc_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   old_msb_q, old_msb_d, new_msb_q, new_msb_d;

    // Registered outputs.
    acc_t                    acc_out_q, acc_out_d;
    logic [VOICE_BITS-1:0]   idx_out_q, idx_out_d;
    logic                    erm_out_q, erm_out_d, rms_out_q, rms_out_d;
    logic                    valid_q, valid_d, done_q, done_d;

    // Datapath helpers.
    acc_t                    upd_val;
    logic                    calc_en, rise;
    logic [VOICE_BITS-1:0]   calc_idx, src_idx;

    // Round sequencing: IDLE -> UPDATE x N -> EMIT x N -> IDLE, with overrun detection.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = state_q;
        v_d         = v_q;
        overrun_d   = overrun_q;
        tick_accept = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d     = UPDATE;
                    v_d         = '0;
                    tick_accept = 1'b1;
                end
            end
            UPDATE: begin
                if (v_q == LAST_V) begin
                    state_d = EMIT;
                    v_d     = '0;
                end else begin
                    v_d = v_q + ONE_V;
                end
            end
            EMIT: begin
                if (v_q == LAST_V) begin
                    state_d = IDLE;
                    v_d     = '0;
                end else begin
                    v_d = v_q + ONE_V;
                end
            end
            default: begin
                state_d = IDLE;
                v_d     = '0;
            end
        endcase
        if (sample_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Live config writes; the shadow copy takes the post-write values on an accepted tick.
    always_comb begin
        freq_d    = freq_q;
        ringmod_d = ringmod_q;
        sync_d    = sync_q;
        test_d    = test_q;
        if (cfg_we && (int'(cfg_voice) < NUM_VOICES)) begin
            freq_d[cfg_voice]    = cfg_freq;
            ringmod_d[cfg_voice] = cfg_ringmod;
            sync_d[cfg_voice]    = cfg_sync;
            test_d[cfg_voice]    = cfg_test;
        end
        sh_freq_d    = tick_accept ? freq_d    : sh_freq_q;
        sh_ringmod_d = tick_accept ? ringmod_d : sh_ringmod_q;
        sh_sync_d    = tick_accept ? sync_d    : sh_sync_q;
        sh_test_d    = tick_accept ? test_d    : sh_test_q;
    end

    // Accumulator update and emission. The output register for voice e is loaded one
    // cycle ahead: voice 0 in the last UPDATE cycle and voice e+1 in EMIT cycle e.
    always_comb begin
        acc_d     = acc_q;
        old_msb_d = old_msb_q;
        new_msb_d = new_msb_q;
        acc_out_d = acc_out_q;
        idx_out_d = idx_out_q;
        erm_out_d = erm_out_q;
        rms_out_d = rms_out_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        calc_en   = 1'b0;
        calc_idx  = '0;
        rise      = 1'b0;

        upd_val = sh_test_q[v_q] ? '0 : acc_q[v_q] + ACCUMULATOR_BITS'(sh_freq_q[v_q]);
        if (state_q == UPDATE) begin
            acc_d[v_q]     = upd_val;
            old_msb_d[v_q] = acc_q[v_q][MSB];
            new_msb_d[v_q] = upd_val[MSB];
        end

        if ((state_q == UPDATE) && (v_q == LAST_V)) begin
            calc_en  = 1'b1;
            calc_idx = '0;
        end else if ((state_q == EMIT) && (v_q != LAST_V)) begin
            calc_en  = 1'b1;
            calc_idx = v_q + ONE_V;
        end
        src_idx = (calc_idx == '0) ? LAST_V : calc_idx - ONE_V;

        // The MSB arrays are never touched by a sync reset, so rises and the ring-mod
        // source always reflect UPDATE results. The *_d view includes the source written
        // in this same cycle.
        if (calc_en) begin
            rise = !old_msb_d[src_idx] && new_msb_d[src_idx];
            if (sh_sync_q[calc_idx] && rise) begin
                acc_d[calc_idx] = '0;
                acc_out_d       = '0;
            end else begin
                acc_out_d = acc_d[calc_idx];
            end
            idx_out_d = calc_idx;
            erm_out_d = sh_ringmod_q[calc_idx];
            rms_out_d = new_msb_d[src_idx];
            valid_d   = 1'b1;
            done_d    = (calc_idx == LAST_V);
        end
    end

    // State, configuration, accumulator and output registers.
    always_ff @(posedge clk) begin
        // NOTE: accumulators are small register arrays rather than RAM, so they are cleared
        // on reset like every other register.
        if (reset) begin
            state_q      <= IDLE;
            v_q          <= '0;
            overrun_q    <= 1'b0;
            freq_q       <= '{default: '0};
            ringmod_q    <= '0;
            sync_q       <= '0;
            test_q       <= '0;
            sh_freq_q    <= '{default: '0};
            sh_ringmod_q <= '0;
            sh_sync_q    <= '0;
            sh_test_q    <= '0;
            acc_q        <= '{default: '0};
            old_msb_q    <= '0;
            new_msb_q    <= '0;
            acc_out_q    <= '0;
            idx_out_q    <= '0;
            erm_out_q    <= 1'b0;
            rms_out_q    <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            v_q          <= v_d;
            overrun_q    <= overrun_d;
            freq_q       <= freq_d;
            ringmod_q    <= ringmod_d;
            sync_q       <= sync_d;
            test_q       <= test_d;
            sh_freq_q    <= sh_freq_d;
            sh_ringmod_q <= sh_ringmod_d;
            sh_sync_q    <= sh_sync_d;
            sh_test_q    <= sh_test_d;
            acc_q        <= acc_d;
            old_msb_q    <= old_msb_d;
            new_msb_q    <= new_msb_d;
            acc_out_q    <= acc_out_d;
            idx_out_q    <= idx_out_d;
            erm_out_q    <= erm_out_d;
            rms_out_q    <= rms_out_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
        end
    end

    assign accumulator    = acc_out_q;
    assign voice_idx      = idx_out_q;
    assign en_ringmod     = erm_out_q;
    assign ringmod_source = rms_out_q;
    assign out_valid      = valid_q;
    assign round_done     = done_q;
    assign busy           = (state_q != IDLE);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_osc_voice_scheduler.sv
// Directed bench for osc_voice_scheduler: reset, timing of one round, accumulator
// wrap, hard-sync, ring-mod, the test bit, overrun, shadow config, back-to-back
// rounds and reset in the middle of a round.
module tb_osc_voice_scheduler;

    logic        clk;
    logic        reset;
    logic        sample_tick;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [15:0] cfg_freq;
    logic        cfg_ringmod, cfg_sync, cfg_test;
    logic [23:0] accumulator;
    logic [1:0]  voice_idx;
    logic        en_ringmod, ringmod_source, out_valid, round_done, busy, overrun;

    int checks   = 0;
    int failures = 0;

    // Per-cycle capture of one round, indexed by cycles after the tick.
    logic [31:0] valid_mask, busy_mask, done_mask, ovr_mask;
    logic [23:0] cyc_acc [32];
    // Per-voice capture, indexed by voice_idx.
    logic [23:0] cap_acc [3];
    logic        cap_rms [3];
    logic        cap_erm [3];
    logic [1:0]  idx_seq [3];
    int          nvalid;

    osc_voice_scheduler #(
        .NUM_VOICES(3), .ACCUMULATOR_BITS(24), .FREQ_BITS(16), .VOICE_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_freq(cfg_freq),
        .cfg_ringmod(cfg_ringmod), .cfg_sync(cfg_sync), .cfg_test(cfg_test),
        .accumulator(accumulator), .voice_idx(voice_idx), .en_ringmod(en_ringmod),
        .ringmod_source(ringmod_source), .out_valid(out_valid), .round_done(round_done),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [15:0] f,
                             input logic rm, input logic sy, input logic ts);
        cfg_voice = v; cfg_freq = f; cfg_ringmod = rm; cfg_sync = sy; cfg_test = ts;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Tick at cycle T, then observe cycles T+1..T+ncyc. Optional extra tick, voice-0
    // write (0 = coinciding with the tick) and reset pulse at chosen offsets.
    task automatic run_round(input int tick2_at, input int wr_at, input logic [15:0] wr_freq,
                             input int rst_at, input int ncyc);
        valid_mask = '0; busy_mask = '0; done_mask = '0; ovr_mask = '0; nvalid = 0;
        for (int v = 0; v < 3; v++) begin
            cap_acc[v] = '0; cap_rms[v] = 1'b0; cap_erm[v] = 1'b0; idx_seq[v] = '0;
        end
        sample_tick = 1'b1;
        if (wr_at == 0) begin
            cfg_voice = 2'd0; cfg_freq = wr_freq; cfg_ringmod = 0; cfg_sync = 0; cfg_test = 0;
            cfg_we = 1'b1;
        end
        step();
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            valid_mask[c] = out_valid;
            busy_mask[c]  = busy;
            done_mask[c]  = round_done;
            ovr_mask[c]   = overrun;
            cyc_acc[c]    = accumulator;
            if (out_valid && (voice_idx < 2'd3)) begin
                cap_acc[voice_idx] = accumulator;
                cap_rms[voice_idx] = ringmod_source;
                cap_erm[voice_idx] = en_ringmod;
                if (nvalid < 3) idx_seq[nvalid] = voice_idx;
                nvalid++;
            end
            sample_tick = (c == tick2_at);
            reset       = (c == rst_at);
            if (c == wr_at) begin
                cfg_voice = 2'd0; cfg_freq = wr_freq; cfg_ringmod = 0; cfg_sync = 0; cfg_test = 0;
                cfg_we = 1'b1;
            end
            step();
            sample_tick = 1'b0;
            reset       = 1'b0;
            cfg_we      = 1'b0;
        end
    endtask

    task automatic plain_round();
        run_round(-1, -1, 16'h0, -1, 9);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (accumulator !== 24'h0) begin failures++; $display("FAIL reset_acc got=%h exp=000000", accumulator); end
        checks++; if (voice_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", voice_idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (round_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", round_done); end
    endtask

    task automatic test_basic_round();
        cfg_write(2'd0, 16'h1000, 0, 0, 0);
        plain_round();
        checks++; if (valid_mask !== 32'h70) begin failures++; $display("FAIL basic_valid_window got=%h exp=00000070", valid_mask); end
        checks++; if (busy_mask !== 32'h7E) begin failures++; $display("FAIL basic_busy_window got=%h exp=0000007e", busy_mask); end
        checks++; if (done_mask !== 32'h40) begin failures++; $display("FAIL basic_round_done got=%h exp=00000040", done_mask); end
        checks++; if ({idx_seq[0], idx_seq[1], idx_seq[2]} !== 6'b00_01_10) begin failures++;
            $display("FAIL basic_voice_order got=%0d,%0d,%0d exp=0,1,2", idx_seq[0], idx_seq[1], idx_seq[2]); end
        checks++; if (cap_acc[0] !== 24'h001000) begin failures++; $display("FAIL basic_acc0 got=%h exp=001000", cap_acc[0]); end
        checks++; if (cap_acc[1] !== 24'h0) begin failures++; $display("FAIL basic_acc1 got=%h exp=000000", cap_acc[1]); end
        checks++; if (cap_acc[2] !== 24'h0) begin failures++; $display("FAIL basic_acc2 got=%h exp=000000", cap_acc[2]); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
    endtask

    // Continues from the basic round: acc0 = 0x1000 with freq0 = 0x1000 still set.
    task automatic test_wrap();
        logic [23:0] exp1;
        exp1 = 24'(257 * 32'hFFFF);   // 0x100FEFF truncated to 0x00FEFF
        cfg_write(2'd1, 16'hFFFF, 0, 0, 0);
        for (int r = 0; r < 257; r++) plain_round();
        checks++; if (cap_acc[1] !== exp1) begin failures++; $display("FAIL wrap_acc1 got=%h exp=%h", cap_acc[1], exp1); end
        checks++; if (cap_acc[0] !== 24'h102000) begin failures++; $display("FAIL wrap_acc0 got=%h exp=102000", cap_acc[0]); end
        checks++; if ($isunknown(cap_acc[1]) !== 1'b0) begin failures++; $display("FAIL wrap_no_x got=%h exp=known", cap_acc[1]); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL wrap_overrun got=%b exp=0", overrun); end
    endtask

    // Voice 2 reaches the MSB in round 256; voice 0 is hard-synced to it.
    task automatic test_sync_and_testbit();
        apply_reset();
        cfg_write(2'd2, 16'h8000, 0, 0, 0);
        cfg_write(2'd0, 16'h0100, 0, 1, 0);
        for (int r = 0; r < 254; r++) plain_round();
        plain_round();   // round 255
        checks++; if (cap_acc[0] !== 24'h00FF00) begin failures++; $display("FAIL sync_r255_acc0 got=%h exp=00ff00", cap_acc[0]); end
        checks++; if (cap_rms[0] !== 1'b0) begin failures++; $display("FAIL sync_r255_rms0 got=%b exp=0", cap_rms[0]); end
        plain_round();   // round 256
        checks++; if (cap_acc[0] !== 24'h0) begin failures++; $display("FAIL sync_r256_acc0 got=%h exp=000000", cap_acc[0]); end
        checks++; if (cap_rms[0] !== 1'b1) begin failures++; $display("FAIL sync_r256_rms0 got=%b exp=1", cap_rms[0]); end
        checks++; if (cap_acc[2] !== 24'h800000) begin failures++; $display("FAIL sync_r256_acc2 got=%h exp=800000", cap_acc[2]); end
        checks++; if (cap_rms[1] !== 1'b0) begin failures++; $display("FAIL sync_r256_rms1 got=%b exp=0", cap_rms[1]); end
        plain_round();   // round 257: sync cleared acc0, no new rise
        checks++; if (cap_acc[0] !== 24'h000100) begin failures++; $display("FAIL sync_r257_acc0 got=%h exp=000100", cap_acc[0]); end
        cfg_write(2'd0, 16'h0100, 0, 1, 1);
        plain_round();
        checks++; if (cap_acc[0] !== 24'h0) begin failures++; $display("FAIL testbit_acc0 got=%h exp=000000", cap_acc[0]); end
        cfg_write(2'd0, 16'h0100, 0, 0, 0);
        plain_round();
        checks++; if (cap_acc[0] !== 24'h000100) begin failures++; $display("FAIL testbit_release got=%h exp=000100", cap_acc[0]); end
    endtask

    // freq0 = 0xFFFF: acc0 = 0x7FFF80 after 128 rounds, 0x80FF7F after 129.
    task automatic test_ringmod();
        apply_reset();
        cfg_write(2'd0, 16'hFFFF, 0, 0, 0);
        cfg_write(2'd1, 16'h0000, 1, 0, 0);
        for (int r = 0; r < 127; r++) plain_round();
        plain_round();
        checks++; if (cap_acc[0] !== 24'h7FFF80) begin failures++; $display("FAIL rm_r128_acc0 got=%h exp=7fff80", cap_acc[0]); end
        checks++; if (cap_rms[1] !== 1'b0) begin failures++; $display("FAIL rm_r128_src1 got=%b exp=0", cap_rms[1]); end
        plain_round();
        checks++; if (cap_erm[1] !== 1'b1) begin failures++; $display("FAIL rm_en1 got=%b exp=1", cap_erm[1]); end
        checks++; if (cap_rms[1] !== 1'b1) begin failures++; $display("FAIL rm_r129_src1 got=%b exp=1", cap_rms[1]); end
        checks++; if (cap_erm[2] !== 1'b0) begin failures++; $display("FAIL rm_en2 got=%b exp=0", cap_erm[2]); end
        checks++; if (cap_erm[0] !== 1'b0) begin failures++; $display("FAIL rm_en0 got=%b exp=0", cap_erm[0]); end
    endtask

    task automatic test_overrun_shadow();
        apply_reset();
        cfg_write(2'd0, 16'h0010, 0, 0, 0);
        run_round(2, 3, 16'h0020, -1, 9);
        checks++; if (valid_mask !== 32'h70) begin failures++; $display("FAIL ovr_valid_window got=%h exp=00000070", valid_mask); end
        checks++; if (cap_acc[0] !== 24'h000010) begin failures++; $display("FAIL ovr_acc0 got=%h exp=000010", cap_acc[0]); end
        checks++; if (ovr_mask !== 32'h3F8) begin failures++; $display("FAIL ovr_flag got=%h exp=000003f8", ovr_mask); end
        plain_round();
        checks++; if (cap_acc[0] !== 24'h000030) begin failures++; $display("FAIL shadow_next_round got=%h exp=000030", cap_acc[0]); end
        checks++; if (ovr_mask !== 32'h3FE) begin failures++; $display("FAIL ovr_sticky got=%h exp=000003fe", ovr_mask); end
    endtask

    // Write coincides with the first tick; second tick lands the cycle after round_done.
    task automatic test_back_to_back();
        apply_reset();
        run_round(7, 0, 16'h0040, -1, 15);
        checks++; if (valid_mask !== 32'h3870) begin failures++; $display("FAIL b2b_valid got=%h exp=00003870", valid_mask); end
        checks++; if (done_mask !== 32'h2040) begin failures++; $display("FAIL b2b_done got=%h exp=00002040", done_mask); end
        checks++; if (busy_mask !== 32'h3F7E) begin failures++; $display("FAIL b2b_busy got=%h exp=00003f7e", busy_mask); end
        checks++; if (cyc_acc[4] !== 24'h000040) begin failures++; $display("FAIL b2b_acc_round1 got=%h exp=000040", cyc_acc[4]); end
        checks++; if (cyc_acc[11] !== 24'h000080) begin failures++; $display("FAIL b2b_acc_round2 got=%h exp=000080", cyc_acc[11]); end
        checks++; if (ovr_mask !== 32'h0) begin failures++; $display("FAIL b2b_overrun got=%h exp=00000000", ovr_mask); end
    endtask

    // Reset sampled at the end of T+5, while voice 1 is being emitted.
    task automatic test_reset_mid_round();
        apply_reset();
        cfg_write(2'd0, 16'h0010, 0, 0, 0);
        run_round(2, -1, 16'h0, 5, 9);
        checks++; if (valid_mask !== 32'h30) begin failures++; $display("FAIL midrst_valid got=%h exp=00000030", valid_mask); end
        checks++; if (busy_mask !== 32'h3E) begin failures++; $display("FAIL midrst_busy got=%h exp=0000003e", busy_mask); end
        checks++; if (ovr_mask !== 32'h38) begin failures++; $display("FAIL midrst_overrun got=%h exp=00000038", ovr_mask); end
        checks++; if (cyc_acc[6] !== 24'h0) begin failures++; $display("FAIL midrst_acc_out got=%h exp=000000", cyc_acc[6]); end
        cfg_write(2'd0, 16'h0010, 0, 0, 0);
        plain_round();
        checks++; if (cap_acc[0] !== 24'h000010) begin failures++; $display("FAIL midrst_acc0 got=%h exp=000010", cap_acc[0]); end
        checks++; if (cap_acc[1] !== 24'h0) begin failures++; $display("FAIL midrst_acc1 got=%h exp=000000", cap_acc[1]); end
        checks++; if (valid_mask !== 32'h70) begin failures++; $display("FAIL midrst_next_valid got=%h exp=00000070", valid_mask); end
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_freq = '0;
        cfg_ringmod = 1'b0; cfg_sync = 1'b0; cfg_test = 1'b0;
        test_reset();
        test_basic_round();
        test_wrap();
        test_sync_and_testbit();
        test_ringmod();
        test_overrun_shadow();
        test_back_to_back();
        test_reset_mid_round();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
